// File: rtl/hilo_div_ctrl_pkg.sv
// Shared types and constants for the HI/LO register and divider sequencer.
package hilo_pkg;

  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_div_ctrl_div_core.sv
// Unsigned restoring divider datapath: one shift-subtract step per cycle while step is high.
module div_core #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [DW-1:0] dividend_abs,
  input  logic [DW-1:0] divisor_abs,
  output logic [DW-1:0] quo,
  output logic [DW-1:0] rem
);

  logic [DW-1:0] rem_r;
  logic [DW-1:0] quo_r;
  logic [DW-1:0] dvs_r;
  logic [DW:0]   rem_sh_s;
  logic [DW+1:0] diff_s;

  // Trial subtraction; the extra top bit of diff_s is the borrow.
  always_comb begin
    rem_sh_s = {rem_r, quo_r[DW-1]};
    diff_s   = {1'b0, rem_sh_s} - {2'b00, dvs_r};
  end

  // Quotient bits enter at the LSB as dividend bits leave the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r <= '0;
      quo_r <= '0;
      dvs_r <= '0;
    end else if (load) begin
      rem_r <= '0;
      quo_r <= dividend_abs;
      dvs_r <= divisor_abs;
    end else if (step) begin
      if (!diff_s[DW+1]) begin
        rem_r <= diff_s[DW-1:0];
        quo_r <= {quo_r[DW-2:0], 1'b1};
      end else begin
        rem_r <= rem_sh_s[DW-1:0];
        quo_r <= {quo_r[DW-2:0], 1'b0};
      end
    end
  end

  assign quo = quo_r;
  assign rem = rem_r;

endmodule

// File: rtl/hilo_div_ctrl.sv
// HI/LO register pair with DIV/DIVU sequencing, PC stall and MTHI/MTLO writes.
// Optional divide-by-zero trap enabled by defining HILO_DIV_ZERO_TRAP_EN.
module hilo_div_ctrl
  import hilo_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_div,
  input  logic          req_divu,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  input  logic          hiin,
  input  logic          loin,
  input  logic [DW-1:0] hilo_wdata,
  output logic          pc_no_add,
  output logic          busy,
  output logic          over,
  output logic [DW-1:0] hi_out,
  output logic [DW-1:0] lo_out
`ifdef HILO_DIV_ZERO_TRAP_EN
  , output logic        div_zero_exc
`endif
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              signed_r, dvd_neg_r, dvs_neg_r, zero_r;
  logic              req_s, load_s, step_s, commit_s, zero_s;
  logic              dvd_neg_s, dvs_neg_s;
  logic [DW-1:0]     dvd_abs_s, dvs_abs_s, quo_s, rem_s, quo_fix_s, rem_fix_s;
  logic [DW-1:0]     hi_r, lo_r;

  assign req_s     = req_div | req_divu;
  assign zero_s    = (divisor == {DW{1'b0}});
  // req_div takes priority, so any request with req_div high is signed.
  assign dvd_neg_s = req_div & dividend[DW-1];
  assign dvs_neg_s = req_div & divisor[DW-1];
  assign dvd_abs_s = dvd_neg_s ? ({DW{1'b0}} - dividend) : dividend;
  assign dvs_abs_s = dvs_neg_s ? ({DW{1'b0}} - divisor) : divisor;

  // Next-state and datapath control.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          load_s = 1'b1;
`ifdef HILO_DIV_ZERO_TRAP_EN
          if (zero_s) state_s = DONE;
          else        state_s = RUN;
`else
          state_s = RUN;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_CNT) state_s = DONE;
        else                   state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM state, step counter and operand sign capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      signed_r  <= 1'b0;
      dvd_neg_r <= 1'b0;
      dvs_neg_r <= 1'b0;
      zero_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (load_s) begin
        cnt_r     <= '0;
        signed_r  <= req_div;
        dvd_neg_r <= dvd_neg_s;
        dvs_neg_r <= dvs_neg_s;
        zero_r    <= zero_s;
      end else if (step_s) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  div_core #(.DW(DW)) u_core (
    .clk          (clk),
    .rst          (rst),
    .load         (load_s),
    .step         (step_s),
    .dividend_abs (dvd_abs_s),
    .divisor_abs  (dvs_abs_s),
    .quo          (quo_s),
    .rem          (rem_s)
  );

  // Negation wraps, so 0x80000000 / -1 naturally yields 0x80000000.
  assign quo_fix_s = (signed_r & (dvd_neg_r ^ dvs_neg_r)) ? ({DW{1'b0}} - quo_s) : quo_s;
  assign rem_fix_s = (signed_r & dvd_neg_r) ? ({DW{1'b0}} - rem_s) : rem_s;

`ifdef HILO_DIV_ZERO_TRAP_EN
  assign commit_s     = (state_r == DONE) & ~zero_r;
  assign div_zero_exc = (state_r == DONE) & zero_r;
`else
  assign commit_s = (state_r == DONE);
`endif

  // HI/LO registers; a division commit overrides MTHI/MTLO in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
    end else if (commit_s) begin
      hi_r <= rem_fix_s;
      lo_r <= quo_fix_s;
    end else begin
      if (hiin) hi_r <= hilo_wdata;
      if (loin) lo_r <= hilo_wdata;
    end
  end

  assign hi_out    = hi_r;
  assign lo_out    = lo_r;
  assign busy      = (state_r == RUN);
  assign over      = (state_r == DONE);
  assign pc_no_add = req_s & (state_r != DONE) & ~rst;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed self-checking bench for hilo_div_ctrl (covers HILO_DIV_ZERO_TRAP_EN when defined).
module tb_hilo_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_div, req_divu, hiin, loin;
  logic [31:0] dividend, divisor, hilo_wdata;
  logic        pc_no_add, busy, over;
  logic [31:0] hi_out, lo_out;
`ifdef HILO_DIV_ZERO_TRAP_EN
  logic        dz;
`endif

  int checks = 0;
  int errors = 0;

  hilo_div_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_div    (req_div),
    .req_divu   (req_divu),
    .dividend   (dividend),
    .divisor    (divisor),
    .hiin       (hiin),
    .loin       (loin),
    .hilo_wdata (hilo_wdata),
    .pc_no_add  (pc_no_add),
    .busy       (busy),
    .over       (over),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
`ifdef HILO_DIV_ZERO_TRAP_EN
    , .div_zero_exc (dz)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode[0]=req_div, mode[1]=req_divu; hold keeps the request for a back-to-back launch;
  // poke fires MTHI/MTLO in the DONE cycle, which the commit must override.
  task automatic run_div(input string tag, input logic [1:0] mode, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi,
                         input bit hold, input bit poke);
    int n;
    bit stall_ok;
    req_div = mode[0]; req_divu = mode[1]; dividend = a; divisor = b;
    #1;
    chk({tag, "_pc_launch"}, {31'd0, pc_no_add}, 32'd1);
    tick();
    n = 1;
    stall_ok = 1'b1;
    while (!over && n < 40) begin
      if (!(pc_no_add && busy)) stall_ok = 1'b0;
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd33);
    chk({tag, "_stall_run"}, {31'd0, stall_ok}, 32'd1);
    chk({tag, "_pc_done"}, {31'd0, pc_no_add}, 32'd0);
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    if (poke) begin
      hiin = 1'b1; loin = 1'b1; hilo_wdata = 32'hDEADBEEF;
    end
    tick();
    hiin = 1'b0; loin = 1'b0;
    chk({tag, "_over_after"}, {31'd0, over}, 32'd0);
    chk({tag, "_lo"}, lo_out, elo);
    chk({tag, "_hi"}, hi_out, ehi);
    if (!hold) begin
      req_div = 1'b0; req_divu = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; req_div = 1'b0; req_divu = 1'b0; hiin = 1'b0; loin = 1'b0;
    dividend = 32'd0; divisor = 32'd0; hilo_wdata = 32'd0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_over", {31'd0, over}, 32'd0);
    chk("rst_pc", {31'd0, pc_no_add}, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
`ifdef HILO_DIV_ZERO_TRAP_EN
    chk("rst_dz", {31'd0, dz}, 32'd0);
`endif
    rst = 1'b0;
    tick();

    // MTHI / MTLO, visible only after the edge
    hiin = 1'b1; hilo_wdata = 32'hA5A5A5A5;
    #1;
    chk("mthi_no_fwd", hi_out, 32'd0);
    tick();
    hiin = 1'b0;
    chk("mthi", hi_out, 32'hA5A5A5A5);
    chk("mthi_lo_keep", lo_out, 32'd0);
    loin = 1'b1; hilo_wdata = 32'h5A5A5A5A;
    tick();
    loin = 1'b0;
    chk("mtlo", lo_out, 32'h5A5A5A5A);
    chk("mtlo_hi_keep", hi_out, 32'hA5A5A5A5);
    hiin = 1'b1; loin = 1'b1; hilo_wdata = 32'h0F0F0F0F;
    tick();
    hiin = 1'b0; loin = 1'b0;
    chk("mtboth_hi", hi_out, 32'h0F0F0F0F);
    chk("mtboth_lo", lo_out, 32'h0F0F0F0F);

    run_div("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    run_div("div_m7_2", 2'b01, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_div("div_7_m2", 2'b01, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 1'b0);
    run_div("div_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b1);

`ifdef HILO_DIV_ZERO_TRAP_EN
    req_divu = 1'b1; dividend = 32'h1234; divisor = 32'd0;
    #1;
    chk("dz_pc_launch", {31'd0, pc_no_add}, 32'd1);
    tick();
    chk("dz_over", {31'd0, over}, 32'd1);
    chk("dz_exc", {31'd0, dz}, 32'd1);
    chk("dz_pc_done", {31'd0, pc_no_add}, 32'd0);
    chk("dz_busy", {31'd0, busy}, 32'd0);
    tick();
    req_divu = 1'b0;
    chk("dz_exc_after", {31'd0, dz}, 32'd0);
    chk("dz_lo_keep", lo_out, 32'h80000000);
    chk("dz_hi_keep", hi_out, 32'd0);
`else
    run_div("divu_zero", 2'b10, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b0, 1'b0);
    run_div("div_m5_zero", 2'b01, 32'hFFFFFFFB, 32'd0, 32'd1, 32'hFFFFFFFB, 1'b0, 1'b0);
`endif

    // back-to-back: second launch in the cycle right after DONE
    run_div("b2b_9_2", 2'b10, 32'd9, 32'd2, 32'd4, 32'd1, 1'b1, 1'b0);
    run_div("b2b_10_3", 2'b10, 32'd10, 32'd3, 32'd3, 32'd1, 1'b0, 1'b0);

    // reset in RUN cycle 10 discards the division
    req_divu = 1'b1; dividend = 32'd50; divisor = 32'd5;
    tick();
    repeat (9) tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_pc", {31'd0, pc_no_add}, 32'd0);
    chk("midrst_hi", hi_out, 32'd0);
    chk("midrst_lo", lo_out, 32'd0);
    tick();
    rst = 1'b0;
    run_div("relaunch_50_5", 2'b10, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b0);

    tick();
    chk("idle_pc", {31'd0, pc_no_add}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
